// File: rtl/l15_amo_req_resp.sv
// l15_amo_req_resp
//   Core-side endpoint for one outstanding atomic memory operation. The core
//   operand is packed into an L2 data line (dword lane, sub-word position and
//   optional per-lane byte reversal), sent toward L2, and the old memory value
//   returned on the response line is extracted, byte-ordered and sign-extended
//   back to the core.
//
// Parameters
//   SWAP_ENDIANESS  1 = byte-reverse each 64-bit lane between core and L2 layout
//   TIMEOUT_CYCLES  WAIT-state cycle limit (timeout build only)
//
// Optional feature macro
//   L15_AMO_TIMEOUT_EN  when defined, WAIT gives up after TIMEOUT_CYCLES cycles
//                       and returns a zero result with core_resp_err_o set.
//                       When undefined, WAIT is held indefinitely and
//                       core_resp_err_o is tied low.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   core_req_val_i / core_req_rdy_o request handshake (ready only in IDLE)
//   core_req_op_i/addr_i/size_i/data_i  AMO opcode, byte address, size, operand
//   l2_req_val_o / l2_req_rdy_i     request toward L2
//   l2_req_op_o/addr_o/size_o       registered copies of the core request
//   l2_req_data_o                   packed operand line
//   l2_resp_val_i / l2_resp_data_i  single-cycle response line (old value)
//   core_resp_val_o / core_resp_rdy_i  result handshake
//   core_resp_data_o                old value, sign-extended to 64 bits
//   core_resp_err_o                 timeout indication

`ifndef L2_AMO_ALU_OP_WIDTH
`define L2_AMO_ALU_OP_WIDTH 4
`endif
`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 40
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 3
`endif
`ifndef MSG_DATA_SIZE_1B
`define MSG_DATA_SIZE_1B 3'b001
`endif
`ifndef MSG_DATA_SIZE_2B
`define MSG_DATA_SIZE_2B 3'b010
`endif
`ifndef MSG_DATA_SIZE_4B
`define MSG_DATA_SIZE_4B 3'b011
`endif
`ifndef MSG_DATA_SIZE_8B
`define MSG_DATA_SIZE_8B 3'b100
`endif
`ifndef L2_DATA_DATA_WIDTH
`define L2_DATA_DATA_WIDTH 128
`endif
`ifndef L2_DATA_DATA_WIDTH_LOG2
`define L2_DATA_DATA_WIDTH_LOG2 7
`endif

module l15_amo_req_resp #(
  parameter int SWAP_ENDIANESS = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              core_req_val_i,
  output logic                              core_req_rdy_o,
  input  logic [`L2_AMO_ALU_OP_WIDTH-1:0]   core_req_op_i,
  input  logic [`PHY_ADDR_WIDTH-1:0]        core_req_addr_i,
  input  logic [`MSG_DATA_SIZE_WIDTH-1:0]   core_req_size_i,
  input  logic [63:0]                       core_req_data_i,
  output logic                              l2_req_val_o,
  input  logic                              l2_req_rdy_i,
  output logic [`L2_AMO_ALU_OP_WIDTH-1:0]   l2_req_op_o,
  output logic [`PHY_ADDR_WIDTH-1:0]        l2_req_addr_o,
  output logic [`MSG_DATA_SIZE_WIDTH-1:0]   l2_req_size_o,
  output logic [`L2_DATA_DATA_WIDTH-1:0]    l2_req_data_o,
  input  logic                              l2_resp_val_i,
  input  logic [`L2_DATA_DATA_WIDTH-1:0]    l2_resp_data_i,
  output logic                              core_resp_val_o,
  input  logic                              core_resp_rdy_i,
  output logic [63:0]                       core_resp_data_o,
  output logic                              core_resp_err_o
);

  // state   | meaning
  // IDLE    | ready for a core request
  // REQ     | packed request presented to L2, waiting for l2_req_rdy_i
  // WAIT    | request accepted, waiting for the response line
  // RESP    | result presented to core, waiting for core_resp_rdy_i
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam int LINE_W  = `L2_DATA_DATA_WIDTH;
  localparam int LANES   = LINE_W / 64;
  localparam int LANE_HI = `L2_DATA_DATA_WIDTH_LOG2 - 4;
  localparam int LANE_W  = LANE_HI - 2;
  localparam int OP_W    = `L2_AMO_ALU_OP_WIDTH;
  localparam int ADDR_W  = `PHY_ADDR_WIDTH;
  localparam int SIZE_W  = `MSG_DATA_SIZE_WIDTH;

  logic [1:0]        state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [SIZE_W-1:0] size_q;
  logic [LINE_W-1:0] line_q;
  logic [63:0]       resp_data_q;
  logic              timeout_hit;

  // Unsupported size encodings map to zero bytes, which zeroes both the
  // packed field and the extracted result without touching the FSM.
  function automatic logic [3:0] size_to_bytes(input logic [SIZE_W-1:0] size);
    logic [3:0] n;
    n = 4'd0;
    case (size)
      `MSG_DATA_SIZE_1B: n = 4'd1;
      `MSG_DATA_SIZE_2B: n = 4'd2;
      `MSG_DATA_SIZE_4B: n = 4'd4;
      `MSG_DATA_SIZE_8B: n = 4'd8;
      default:           n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic [63:0] byte_mask(input logic [3:0] n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < n) m[i*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

  function automatic logic [63:0] lane_order(input logic [63:0] v);
    logic [63:0] r;
    r = v;
    if (SWAP_ENDIANESS != 0) begin
      for (int i = 0; i < 8; i++) r[i*8 +: 8] = v[(7-i)*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] sign_extend(input logic [63:0] v, input logic [3:0] n);
    logic [63:0] r;
    case (n)
      4'd1:    r = {{56{v[7]}},  v[7:0]};
      4'd2:    r = {{48{v[15]}}, v[15:0]};
      4'd4:    r = {{32{v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Request packing. Bytes shifted past the top of the lane are dropped, so a
  // misaligned address never spills into a neighbouring lane.
  logic [3:0]        req_nbytes;
  logic [2:0]        req_off;
  logic [LANE_W-1:0] req_lane;
  logic [63:0]       req_word;
  logic [LINE_W-1:0] req_line;

  always_comb begin
    req_nbytes = size_to_bytes(core_req_size_i);
    req_off    = core_req_addr_i[2:0];
    req_lane   = core_req_addr_i[LANE_HI:3];
    req_word   = lane_order((core_req_data_i & byte_mask(req_nbytes)) << {req_off, 3'b000});
    req_line   = '0;
    for (int l = 0; l < LANES; l++) begin
      if (LANE_W'(l) == req_lane) req_line[l*64 +: 64] = req_word;
    end
  end

  // Response extraction uses the registered request fields.
  logic [3:0]        rsp_nbytes;
  logic [2:0]        rsp_off;
  logic [LANE_W-1:0] rsp_lane;
  logic [63:0]       rsp_word;
  logic [63:0]       rsp_value;

  always_comb begin
    rsp_nbytes = size_to_bytes(size_q);
    rsp_off    = addr_q[2:0];
    rsp_lane   = addr_q[LANE_HI:3];
    rsp_word   = '0;
    for (int l = 0; l < LANES; l++) begin
      if (LANE_W'(l) == rsp_lane) rsp_word = l2_resp_data_i[l*64 +: 64];
    end
    rsp_value = sign_extend((lane_order(rsp_word) >> {rsp_off, 3'b000}) & byte_mask(rsp_nbytes),
                            rsp_nbytes);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (core_req_val_i)                 state_d = ST_REQ;
      ST_REQ:  if (l2_req_rdy_i)                   state_d = ST_WAIT;
      ST_WAIT: if (l2_resp_val_i || timeout_hit)   state_d = ST_RESP;
      ST_RESP: if (core_resp_rdy_i)                state_d = ST_IDLE;
      default:                                     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      line_q      <= '0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && core_req_val_i) begin
        op_q   <= core_req_op_i;
        addr_q <= core_req_addr_i;
        size_q <= core_req_size_i;
        line_q <= req_line;
      end
      if (state_q == ST_WAIT && l2_resp_val_i) begin
        resp_data_q <= rsp_value;
      end else if (timeout_hit) begin
        resp_data_q <= '0;
      end
    end
  end

`ifdef L15_AMO_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  // Counter is held at zero in REQ so WAIT always starts from a clean count.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_REQ)       wait_cnt_d = '0;
    else if (state_q == ST_WAIT) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == ST_WAIT) && !l2_resp_val_i &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    err_d = err_q;
    if (timeout_hit)                                err_d = 1'b1;
    else if (state_q == ST_RESP && core_resp_rdy_i) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign core_resp_err_o = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign core_resp_err_o    = 1'b0;
`endif

  assign core_req_rdy_o   = (state_q == ST_IDLE);
  assign l2_req_val_o     = (state_q == ST_REQ);
  assign core_resp_val_o  = (state_q == ST_RESP);
  assign l2_req_op_o      = op_q;
  assign l2_req_addr_o    = addr_q;
  assign l2_req_size_o    = size_q;
  assign l2_req_data_o    = line_q;
  assign core_resp_data_o = resp_data_q;

endmodule

// File: tb/tb_l15_amo_req_resp.sv
`ifndef L2_AMO_ALU_OP_WIDTH
`define L2_AMO_ALU_OP_WIDTH 4
`endif
`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 40
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 3
`endif
`ifndef MSG_DATA_SIZE_1B
`define MSG_DATA_SIZE_1B 3'b001
`endif
`ifndef MSG_DATA_SIZE_2B
`define MSG_DATA_SIZE_2B 3'b010
`endif
`ifndef MSG_DATA_SIZE_4B
`define MSG_DATA_SIZE_4B 3'b011
`endif
`ifndef MSG_DATA_SIZE_8B
`define MSG_DATA_SIZE_8B 3'b100
`endif
`ifndef L2_DATA_DATA_WIDTH
`define L2_DATA_DATA_WIDTH 128
`endif
`ifndef L2_DATA_DATA_WIDTH_LOG2
`define L2_DATA_DATA_WIDTH_LOG2 7
`endif
`ifndef L2_AMO_ALU_ADD
`define L2_AMO_ALU_ADD 4'b0100
`endif
`ifndef L2_AMO_ALU_MAXU
`define L2_AMO_ALU_MAXU 4'b1001
`endif

module tb_l15_amo_req_resp;
  localparam int SWAP = 1;
  localparam int TMO  = 16;

  logic                              clk = 1'b0;
  logic                              rst_n = 1'b0;
  logic                              core_req_val_i = 1'b0;
  logic                              core_req_rdy_o;
  logic [`L2_AMO_ALU_OP_WIDTH-1:0]   core_req_op_i = '0;
  logic [`PHY_ADDR_WIDTH-1:0]        core_req_addr_i = '0;
  logic [`MSG_DATA_SIZE_WIDTH-1:0]   core_req_size_i = '0;
  logic [63:0]                       core_req_data_i = '0;
  logic                              l2_req_val_o;
  logic                              l2_req_rdy_i = 1'b0;
  logic [`L2_AMO_ALU_OP_WIDTH-1:0]   l2_req_op_o;
  logic [`PHY_ADDR_WIDTH-1:0]        l2_req_addr_o;
  logic [`MSG_DATA_SIZE_WIDTH-1:0]   l2_req_size_o;
  logic [`L2_DATA_DATA_WIDTH-1:0]    l2_req_data_o;
  logic                              l2_resp_val_i = 1'b0;
  logic [`L2_DATA_DATA_WIDTH-1:0]    l2_resp_data_i = '0;
  logic                              core_resp_val_o;
  logic                              core_resp_rdy_i = 1'b0;
  logic [63:0]                       core_resp_data_o;
  logic                              core_resp_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l15_amo_req_resp #(.SWAP_ENDIANESS(SWAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_val_i(core_req_val_i), .core_req_rdy_o(core_req_rdy_o),
    .core_req_op_i(core_req_op_i), .core_req_addr_i(core_req_addr_i),
    .core_req_size_i(core_req_size_i), .core_req_data_i(core_req_data_i),
    .l2_req_val_o(l2_req_val_o), .l2_req_rdy_i(l2_req_rdy_i),
    .l2_req_op_o(l2_req_op_o), .l2_req_addr_o(l2_req_addr_o),
    .l2_req_size_o(l2_req_size_o), .l2_req_data_o(l2_req_data_o),
    .l2_resp_val_i(l2_resp_val_i), .l2_resp_data_i(l2_resp_data_i),
    .core_resp_val_o(core_resp_val_o), .core_resp_rdy_i(core_resp_rdy_i),
    .core_resp_data_o(core_resp_data_o), .core_resp_err_o(core_resp_err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (byte-level) ----------------
  function automatic int nbytes_of(input logic [2:0] s);
    case (s)
      `MSG_DATA_SIZE_1B: return 1;
      `MSG_DATA_SIZE_2B: return 2;
      `MSG_DATA_SIZE_4B: return 4;
      `MSG_DATA_SIZE_8B: return 8;
      default:           return 0;
    endcase
  endfunction

  // Line byte holding the i-th operand byte, or -1 when it falls off the lane.
  function automatic int line_byte(input logic [39:0] addr, input int i);
    int p;
    p = int'(addr[2:0]) + i;
    if (p > 7) return -1;
    return int'(addr[3]) * 8 + ((SWAP != 0) ? 7 - p : p);
  endfunction

  function automatic logic [127:0] model_pack(input logic [39:0] addr, input logic [2:0] size,
                                              input logic [63:0] data);
    logic [127:0] r;
    int b;
    r = '0;
    for (int i = 0; i < nbytes_of(size); i++) begin
      b = line_byte(addr, i);
      if (b >= 0) r[b*8 +: 8] = data[i*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] model_result(input logic [39:0] addr, input logic [2:0] size,
                                               input logic [127:0] line);
    logic [63:0] v;
    int n, b;
    v = '0;
    n = nbytes_of(size);
    for (int i = 0; i < n; i++) begin
      b = line_byte(addr, i);
      if (b >= 0) v[i*8 +: 8] = line[b*8 +: 8];
    end
    if (n > 0 && n < 8 && v[n*8-1]) v = v | (~64'd0 << (n*8));
    return v;
  endfunction

  // ---------------- transaction driver (no checking) ----------------
  task automatic run_amo(input logic [3:0] op, input logic [39:0] addr, input logic [2:0] size,
                         input logic [63:0] data, input logic [127:0] resp,
                         input int req_stall, input int resp_lat, input int core_stall,
                         output logic [127:0] line_obs, output logic [63:0] res_obs,
                         output logic err_obs, output bit hung);
    int n;
    hung = 1'b0;
    n = 0;
    while (core_req_rdy_o !== 1'b1 && n < 50) begin step(); n++; end
    if (core_req_rdy_o !== 1'b1) hung = 1'b1;
    core_req_val_i = 1'b1; core_req_op_i = op; core_req_addr_i = addr;
    core_req_size_i = size; core_req_data_i = data;
    step();
    core_req_val_i = 1'b0;
    core_req_data_i = {$urandom(), $urandom()};
    n = 0;
    while (l2_req_val_o !== 1'b1 && n < 50) begin step(); n++; end
    if (l2_req_val_o !== 1'b1) hung = 1'b1;
    line_obs = l2_req_data_o;
    repeat (req_stall) step();
    l2_req_rdy_i = 1'b1;
    step();
    l2_req_rdy_i = 1'b0;
    repeat (resp_lat) step();
    l2_resp_val_i = 1'b1; l2_resp_data_i = resp;
    step();
    l2_resp_val_i = 1'b0; l2_resp_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    n = 0;
    while (core_resp_val_o !== 1'b1 && n < 50) begin step(); n++; end
    if (core_resp_val_o !== 1'b1) hung = 1'b1;
    res_obs = core_resp_data_o;
    err_obs = core_resp_err_o;
    repeat (core_stall) step();
    core_resp_rdy_i = 1'b1;
    step();
    core_resp_rdy_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++; if (core_req_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_req_rdy: got %b expected 1", core_req_rdy_o); end
    checks++; if (l2_req_val_o !== 1'b0) begin errors++; $display("FAIL reset_l2_req_val: got %b expected 0", l2_req_val_o); end
    checks++; if (core_resp_val_o !== 1'b0) begin errors++; $display("FAIL reset_resp_val: got %b expected 0", core_resp_val_o); end
    checks++; if (core_resp_err_o !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", core_resp_err_o); end
    checks++; if (core_resp_data_o !== 64'd0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", core_resp_data_o); end
    checks++; if ({l2_req_op_o, l2_req_addr_o, l2_req_size_o} !== '0) begin errors++; $display("FAIL reset_l2_fields: got %h/%h/%h expected 0", l2_req_op_o, l2_req_addr_o, l2_req_size_o); end
    checks++; if (l2_req_data_o !== 128'd0) begin errors++; $display("FAIL reset_l2_data: got %h expected 0", l2_req_data_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_spec_vectors();
    logic [127:0] line; logic [63:0] res; logic err; bit hung;
    run_amo(`L2_AMO_ALU_ADD, 40'h1C, `MSG_DATA_SIZE_4B, 64'h80000001,
            {64'h00000000_FFFFFF7F, 64'h0}, 0, 0, 0, line, res, err, hung);
    checks++; if (hung !== 1'b0) begin errors++; $display("FAIL vec1_handshake: got hung=%b expected 0", hung); end
    checks++; if (line !== {64'h00000000_01000080, 64'h0}) begin errors++; $display("FAIL vec1_pack: got %h expected %h", line, {64'h00000000_01000080, 64'h0}); end
    checks++; if (res !== 64'h00000000_7FFFFFFF) begin errors++; $display("FAIL vec1_result: got %h expected 000000007fffffff", res); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL vec1_err: got %b expected 0", err); end
    run_amo(`L2_AMO_ALU_ADD, 40'h1C, `MSG_DATA_SIZE_4B, 64'h80000001,
            {64'h00000000_00000080, 64'h0}, 1, 2, 1, line, res, err, hung);
    checks++; if (res !== 64'hFFFFFFFF_80000000) begin errors++; $display("FAIL vec2_sign_ext: got %h expected ffffffff80000000", res); end
    // 1B at offset 3: byte position 3 lands in byte 4 of the lane after reversal
    run_amo(`L2_AMO_ALU_ADD, 40'h03, `MSG_DATA_SIZE_1B, 64'hAB,
            {64'h0, 64'h000000F0_00000000}, 0, 1, 0, line, res, err, hung);
    checks++; if (line !== {64'h0, 64'h000000AB_00000000}) begin errors++; $display("FAIL vec3_pack: got %h expected %h", line, {64'h0, 64'h000000AB_00000000}); end
    checks++; if (res !== 64'hFFFFFFFF_FFFFFFF0) begin errors++; $display("FAIL vec3_result: got %h expected fffffffffffffff0", res); end
  endtask

  task automatic test_stall();
    logic [39:0] addr; logic [63:0] data, held; logic [127:0] exp_line, resp;
    addr = 40'h0; data = {$urandom(), $urandom()};
    resp = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_line = model_pack(addr, `MSG_DATA_SIZE_8B, data);
    core_req_val_i = 1'b1; core_req_op_i = `L2_AMO_ALU_MAXU; core_req_addr_i = addr;
    core_req_size_i = `MSG_DATA_SIZE_8B; core_req_data_i = data;
    step();
    core_req_val_i = 1'b0; core_req_data_i = ~data; core_req_addr_i = 40'hFF_FFFF_FFF8;
    for (int k = 0; k < 5; k++) begin
      checks++; if (l2_req_val_o !== 1'b1) begin errors++; $display("FAIL stall_val_%0d: got %b expected 1", k, l2_req_val_o); end
      checks++; if ({l2_req_data_o, l2_req_addr_o, l2_req_op_o, l2_req_size_o} !== {exp_line, addr, 4'(`L2_AMO_ALU_MAXU), 3'(`MSG_DATA_SIZE_8B)})
        begin errors++; $display("FAIL stall_fields_%0d: got %h/%h/%h/%h expected %h/%h", k, l2_req_data_o, l2_req_addr_o, l2_req_op_o, l2_req_size_o, exp_line, addr); end
      l2_resp_val_i = (k == 2); l2_resp_data_i = ~resp;
      step();
      l2_resp_val_i = 1'b0;
    end
    // accept and a response beat in the same REQ cycle: the beat must be dropped
    l2_req_rdy_i = 1'b1; l2_resp_val_i = 1'b1; l2_resp_data_i = ~resp;
    step();
    l2_req_rdy_i = 1'b0; l2_resp_val_i = 1'b0;
    step(); step();
    checks++; if (core_resp_val_o !== 1'b0 || l2_req_val_o !== 1'b0) begin errors++; $display("FAIL stall_req_beat_ignored: got resp_val=%b l2_val=%b expected 0/0", core_resp_val_o, l2_req_val_o); end
    l2_resp_val_i = 1'b1; l2_resp_data_i = resp;
    step();
    l2_resp_val_i = 1'b0; l2_resp_data_i = ~resp;
    checks++; if (core_resp_val_o !== 1'b1) begin errors++; $display("FAIL stall_resp_val: got %b expected 1", core_resp_val_o); end
    checks++; if (core_resp_data_o !== model_result(addr, `MSG_DATA_SIZE_8B, resp)) begin errors++; $display("FAIL stall_resp_data: got %h expected %h", core_resp_data_o, model_result(addr, `MSG_DATA_SIZE_8B, resp)); end
    held = model_result(addr, `MSG_DATA_SIZE_8B, resp);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (core_resp_val_o !== 1'b1 || core_resp_data_o !== held) begin errors++; $display("FAIL stall_resp_hold_%0d: got val=%b data=%h expected 1/%h", k, core_resp_val_o, core_resp_data_o, held); end
    end
    core_resp_rdy_i = 1'b1;
    step();
    core_resp_rdy_i = 1'b0;
    checks++; if (core_req_rdy_o !== 1'b1 || core_resp_val_o !== 1'b0) begin errors++; $display("FAIL stall_return_idle: got rdy=%b val=%b expected 1/0", core_req_rdy_o, core_resp_val_o); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] addr; logic [63:0] data; logic [127:0] resp;
    l2_req_rdy_i = 1'b1; core_resp_rdy_i = 1'b1;
    for (int t = 0; t < 2; t++) begin
      addr = 40'({$urandom(), $urandom()}) & ~40'h3;
      data = {$urandom(), $urandom()};
      resp = {$urandom(), $urandom(), $urandom(), $urandom()};
      core_req_val_i = 1'b1; core_req_addr_i = addr; core_req_size_i = `MSG_DATA_SIZE_4B; core_req_data_i = data;
      step();
      core_req_val_i = 1'b0;
      checks++; if (l2_req_val_o !== 1'b1 || core_req_rdy_o !== 1'b0) begin errors++; $display("FAIL b2b_%0d_req: got l2_val=%b rdy=%b expected 1/0", t, l2_req_val_o, core_req_rdy_o); end
      step();
      checks++; if (l2_req_val_o !== 1'b0 || core_resp_val_o !== 1'b0) begin errors++; $display("FAIL b2b_%0d_wait: got l2_val=%b resp_val=%b expected 0/0", t, l2_req_val_o, core_resp_val_o); end
      l2_resp_val_i = 1'b1; l2_resp_data_i = resp;
      step();
      l2_resp_val_i = 1'b0;
      checks++; if (core_resp_val_o !== 1'b1 || core_resp_data_o !== model_result(addr, `MSG_DATA_SIZE_4B, resp))
        begin errors++; $display("FAIL b2b_%0d_resp: got val=%b data=%h expected 1/%h", t, core_resp_val_o, core_resp_data_o, model_result(addr, `MSG_DATA_SIZE_4B, resp)); end
      step();
      checks++; if (core_req_rdy_o !== 1'b1 || core_resp_val_o !== 1'b0) begin errors++; $display("FAIL b2b_%0d_idle: got rdy=%b val=%b expected 1/0", t, core_req_rdy_o, core_resp_val_o); end
    end
    l2_req_rdy_i = 1'b0; core_resp_rdy_i = 1'b0;
  endtask

  task automatic enter_wait(input logic [63:0] data);
    core_req_val_i = 1'b1; core_req_addr_i = 40'h8; core_req_size_i = `MSG_DATA_SIZE_8B; core_req_data_i = data;
    step();
    core_req_val_i = 1'b0;
    l2_req_rdy_i = 1'b1;
    step();
    l2_req_rdy_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    enter_wait(64'hDEAD_BEEF_0123_4567);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (core_req_rdy_o !== 1'b1 || l2_req_val_o !== 1'b0 || core_resp_val_o !== 1'b0)
      begin errors++; $display("FAIL rstmid_idle: got rdy=%b l2_val=%b resp_val=%b expected 1/0/0", core_req_rdy_o, l2_req_val_o, core_resp_val_o); end
    checks++; if (l2_req_data_o !== 128'd0) begin errors++; $display("FAIL rstmid_l2_data: got %h expected 0", l2_req_data_o); end
    l2_resp_val_i = 1'b1; l2_resp_data_i = '1;
    step();
    l2_resp_val_i = 1'b0;
    step();
    checks++; if (core_resp_val_o !== 1'b0 || core_req_rdy_o !== 1'b1) begin errors++; $display("FAIL rstmid_stray_resp: got val=%b rdy=%b expected 0/1", core_resp_val_o, core_req_rdy_o); end
  endtask

  task automatic test_wait_limit();
    int bad;
    enter_wait(64'h1122_3344_5566_7788);
`ifdef L15_AMO_TIMEOUT_EN
    bad = 0;
    for (int k = 1; k <= TMO; k++) begin
      step();
      if (core_resp_val_o !== (k == TMO)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL timeout_cycle: got %0d wrong cycles expected val only at cycle %0d", bad, TMO); end
    checks++; if (core_resp_err_o !== 1'b1 || core_resp_data_o !== 64'd0) begin errors++; $display("FAIL timeout_result: got err=%b data=%h expected 1/0", core_resp_err_o, core_resp_data_o); end
    l2_resp_val_i = 1'b1; l2_resp_data_i = '1;
    step();
    l2_resp_val_i = 1'b0;
    checks++; if (core_resp_data_o !== 64'd0 || core_resp_err_o !== 1'b1) begin errors++; $display("FAIL timeout_stray: got err=%b data=%h expected 1/0", core_resp_err_o, core_resp_data_o); end
    core_resp_rdy_i = 1'b1;
    step();
    core_resp_rdy_i = 1'b0;
    checks++; if (core_resp_err_o !== 1'b0 || core_req_rdy_o !== 1'b1) begin errors++; $display("FAIL timeout_err_clear: got err=%b rdy=%b expected 0/1", core_resp_err_o, core_req_rdy_o); end
`else
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (core_resp_val_o !== 1'b0 || core_req_rdy_o !== 1'b0 || l2_req_val_o !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wait_hold: got %0d cycles out of WAIT expected 0", bad); end
    l2_resp_val_i = 1'b1; l2_resp_data_i = {64'h0000_0000_0000_00AA, 64'h0};
    step();
    l2_resp_val_i = 1'b0;
    checks++; if (core_resp_val_o !== 1'b1 || core_resp_err_o !== 1'b0) begin errors++; $display("FAIL wait_release: got val=%b err=%b expected 1/0", core_resp_val_o, core_resp_err_o); end
    core_resp_rdy_i = 1'b1;
    step();
    core_resp_rdy_i = 1'b0;
`endif
  endtask

  task automatic test_bad_size();
    logic [127:0] line; logic [63:0] res; logic err; bit hung;
    logic [2:0] sizes [2];
    sizes[0] = 3'b000; sizes[1] = 3'b111;
    for (int i = 0; i < 2; i++) begin
      run_amo(`L2_AMO_ALU_ADD, 40'h10, sizes[i], 64'hFFFF_FFFF_FFFF_FFFF, '1, 0, 0, 0, line, res, err, hung);
      checks++; if (hung !== 1'b0 || line !== 128'd0 || res !== 64'd0)
        begin errors++; $display("FAIL bad_size_%0d: got hung=%b line=%h res=%h expected 0/0/0", i, hung, line, res); end
    end
  endtask

  task automatic test_random();
    logic [127:0] line, resp; logic [63:0] res, data; logic err; bit hung;
    logic [39:0] addr; logic [2:0] size; int n;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 8))
        0, 1:    size = `MSG_DATA_SIZE_1B;
        2, 3:    size = `MSG_DATA_SIZE_2B;
        4, 5:    size = `MSG_DATA_SIZE_4B;
        6, 7:    size = `MSG_DATA_SIZE_8B;
        default: size = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(5, 7));
      endcase
      n = nbytes_of(size);
      addr = 40'({$urandom(), $urandom()});
      if (n > 0) addr = addr & ~40'(n - 1);
      data = {$urandom(), $urandom()};
      resp = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_amo(4'($urandom_range(0, 15)), addr, size, data, resp,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), line, res, err, hung);
      checks++; if (hung !== 1'b0) begin errors++; $display("FAIL rand_%0d_handshake: got hung=%b expected 0", it, hung); end
      checks++; if (line !== model_pack(addr, size, data)) begin errors++; $display("FAIL rand_%0d_pack: got %h expected %h", it, line, model_pack(addr, size, data)); end
      checks++; if (res !== model_result(addr, size, resp) || err !== 1'b0) begin errors++; $display("FAIL rand_%0d_result: got %h err=%b expected %h err=0", it, res, err, model_result(addr, size, resp)); end
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_stall();
    test_back_to_back();
    test_bad_size();
    test_random();
    test_reset_mid();
    test_wait_limit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
